// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and defaults for the unified-memory port arbiter.
//   arb_state_t      : response FSM state, naming which requester owns the
//                      read data arriving this cycle.
//   DEFAULT_STARVE_LIMIT : default number of consecutive data grants allowed
//                      while a fetch is waiting.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_F  = 2'd1,
        RESP_LD = 2'd2,
        RESP_ST = 2'd3
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 3;

endpackage

// File: rtl/starve_counter.sv
// starve_counter
//   Saturating up-counter with synchronous clear. Counts consecutive data
//   grants taken while fetch is waiting; saturates at LIMIT.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-high; clears the count
//     inc    in   increment request
//     clr    in   clear request (wins over inc)
//     cnt    out  CNTWIDTH  current count
module starve_counter #(
    parameter int CNTWIDTH = 2,
    parameter int LIMIT    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [CNTWIDTH-1:0] cnt
);

    localparam logic [CNTWIDTH-1:0] LIMIT_C = CNTWIDTH'(LIMIT);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_C)) begin
            cnt <= cnt + CNTWIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single-ported unified memory between instruction fetch and
//   the data (load/store) stage. Data has priority; after STARVELIMIT
//   consecutive data grants against a waiting fetch, the fetch wins one cycle.
//   Read data returns one cycle after the grant and is routed to its owner.
//   Ports:
//     clock, reset                  clock, synchronous active-high reset
//     fetchReq/fetchAddr            fetch request and instruction address
//     fetchGnt/fetchValid/fetchInstr  fetch grant, response valid, instruction
//     dataReq/dataWe/dataAddr/dataWdata  data request, store flag, addr, data
//     dataGnt/dataValid/dataRdata   data grant, response valid, load data
//     memEn/memWe/memAddr/memWdata  memory port controls
//     memRdata                      synchronous memory read data
//     stallFetch/stallData          request pending but not granted
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int STARVELIMIT      = DEFAULT_STARVE_LIMIT,
    parameter int CNTWIDTH         = 2
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic                        fetchReq,
    input  logic [WIDTH-1:0]            fetchAddr,
    output logic                        fetchGnt,
    output logic                        fetchValid,
    output logic [INSTRUCTIONWIDTH-1:0] fetchInstr,

    input  logic                        dataReq,
    input  logic                        dataWe,
    input  logic [WIDTH-1:0]            dataAddr,
    input  logic [WIDTH-1:0]            dataWdata,
    output logic                        dataGnt,
    output logic                        dataValid,
    output logic [WIDTH-1:0]            dataRdata,

    output logic                        memEn,
    output logic                        memWe,
    output logic [WIDTH-1:0]            memAddr,
    output logic [INSTRUCTIONWIDTH-1:0] memWdata,
    input  logic [INSTRUCTIONWIDTH-1:0] memRdata,

    output logic                        stallFetch,
    output logic                        stallData
);

    localparam logic [CNTWIDTH-1:0] LIMIT_C = CNTWIDTH'(STARVELIMIT);

    logic [CNTWIDTH-1:0]         starveCnt;
    arb_state_t                  respState_p1;
    arb_state_t                  respStateNext;
    logic [INSTRUCTIONWIDTH-1:0] instrHold_p1;
    logic [WIDTH-1:0]            loadHold_p1;

    // ---- Stage p0: request cycle (grant, port mux, stalls) ----

    always_comb begin
        dataGnt  = 1'b0;
        fetchGnt = 1'b0;
        if (!reset) begin
            dataGnt  = dataReq && !(fetchReq && (starveCnt == LIMIT_C));
            fetchGnt = fetchReq && !dataGnt;
        end
    end

    assign stallFetch = fetchReq && !fetchGnt;
    assign stallData  = dataReq && !dataGnt;

    always_comb begin
        memEn    = fetchGnt || dataGnt;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        if (dataGnt) begin
            memAddr  = dataAddr;
            memWe    = dataWe;
            memWdata = {{(INSTRUCTIONWIDTH-WIDTH){1'b0}}, dataWdata};
        end else if (fetchGnt) begin
            memAddr = fetchAddr;
        end
    end

    // Counter clears whenever fetch is served or stops asking, so it only
    // measures an unbroken run of data grants against a waiting fetch.
    starve_counter #(
        .CNTWIDTH (CNTWIDTH),
        .LIMIT    (STARVELIMIT)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (dataGnt && fetchReq),
        .clr   (fetchGnt || !fetchReq),
        .cnt   (starveCnt)
    );

    always_comb begin
        respStateNext = IDLE;
        if (fetchGnt) begin
            respStateNext = RESP_F;
        end else if (dataGnt) begin
            respStateNext = dataWe ? RESP_ST : RESP_LD;
        end
    end

    // ---- Stage p1: response cycle (read data routing, hold registers) ----

    always_ff @(posedge clock) begin
        if (reset) begin
            respState_p1 <= IDLE;
        end else begin
            respState_p1 <= respStateNext;
        end
    end

    // Holds capture only real read responses; a store response leaves the
    // load hold untouched. Reset discards a response still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            instrHold_p1 <= '0;
            loadHold_p1  <= '0;
        end else begin
            if (respState_p1 == RESP_F) begin
                instrHold_p1 <= memRdata;
            end
            if (respState_p1 == RESP_LD) begin
                loadHold_p1 <= memRdata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        fetchValid = 1'b0;
        dataValid  = 1'b0;
        fetchInstr = instrHold_p1;
        dataRdata  = loadHold_p1;
        if (!reset) begin
            unique case (respState_p1)
                RESP_F: begin
                    fetchValid = 1'b1;
                    fetchInstr = memRdata;
                end
                RESP_LD: begin
                    dataValid = 1'b1;
                    dataRdata = memRdata[WIDTH-1:0];
                end
                RESP_ST: begin
                    dataValid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int WIDTH = 16;
    localparam int IW    = 24;
    localparam int SL    = 3;
    localparam int CW    = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetchReq;
    logic [15:0]   fetchAddr;
    logic          fetchGnt, fetchValid;
    logic [23:0]   fetchInstr;
    logic          dataReq, dataWe;
    logic [15:0]   dataAddr, dataWdata;
    logic          dataGnt, dataValid;
    logic [15:0]   dataRdata;
    logic          memEn, memWe;
    logic [15:0]   memAddr;
    logic [23:0]   memWdata;
    logic [23:0]   memRdata;
    logic          stallFetch, stallData;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW), .STARVELIMIT(SL), .CNTWIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGnt(fetchGnt),
        .fetchValid(fetchValid), .fetchInstr(fetchInstr),
        .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr),
        .dataWdata(dataWdata), .dataGnt(dataGnt), .dataValid(dataValid),
        .dataRdata(dataRdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata),
        .stallFetch(stallFetch), .stallData(stallData)
    );

    // Synchronous single-port memory model.
    logic [23:0] mem    [0:255];
    logic [23:0] refMem [0:255];

    always @(posedge clock) begin
        if (memEn) begin
            if (memWe) mem[memAddr[7:0]] <= memWdata;
            else       memRdata <= mem[memAddr[7:0]];
        end
    end

    typedef struct {
        logic        fReq;
        logic [15:0] fAddr;
        logic        dReq;
        logic        dWe;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        logic        eFG;
        logic        eDG;
    } vec_t;

    typedef struct {
        bit          isFetch;
        bit          isStore;
        logic [23:0] val;
    } resp_t;

    resp_t       sb[$];
    vec_t        tbl[$];
    int          passCnt  = 0;
    int          totalCnt = 0;
    logic [23:0] lastFetchRef;
    logic [15:0] lastLoadRef;

    function automatic vec_t mk(input logic fReq, input logic [15:0] fAddr,
                                input logic dReq, input logic dWe,
                                input logic [15:0] dAddr, input logic [15:0] dWdata,
                                input logic eFG, input logic eDG);
        vec_t v;
        v.fReq = fReq; v.fAddr = fAddr; v.dReq = dReq; v.dWe = dWe;
        v.dAddr = dAddr; v.dWdata = dWdata; v.eFG = eFG; v.eDG = eDG;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idleInputs();
        fetchReq = 0; fetchAddr = 0; dataReq = 0; dataWe = 0; dataAddr = 0; dataWdata = 0;
    endtask

    // One clock: drive, check at negedge, advance to just after posedge.
    task automatic runCycle(input vec_t v, input string tag);
        resp_t r;
        logic [15:0] expAddr;
        fetchReq = v.fReq; fetchAddr = v.fAddr;
        dataReq = v.dReq; dataWe = v.dWe; dataAddr = v.dAddr; dataWdata = v.dWdata;
        @(negedge clock);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.isFetch) begin
                check({tag, " fetchResp valids"}, {30'd0, fetchValid, dataValid}, 32'b10);
                check({tag, " fetchInstr"}, {8'd0, fetchInstr}, {8'd0, r.val});
                check({tag, " dataRdata hold"}, {16'd0, dataRdata}, {16'd0, lastLoadRef});
                lastFetchRef = r.val;
            end else begin
                check({tag, " dataResp valids"}, {30'd0, fetchValid, dataValid}, 32'b01);
                check({tag, " dataRdata"}, {16'd0, dataRdata}, {16'd0, r.val[15:0]});
                check({tag, " fetchInstr hold"}, {8'd0, fetchInstr}, {8'd0, lastFetchRef});
                if (!r.isStore) lastLoadRef = r.val[15:0];
            end
        end else begin
            check({tag, " idle valids"}, {30'd0, fetchValid, dataValid}, 32'b00);
            check({tag, " holds"}, {fetchInstr[15:0], dataRdata}, {lastFetchRef[15:0], lastLoadRef});
        end
        check({tag, " grants/stalls"}, {28'd0, fetchGnt, dataGnt, stallFetch, stallData},
              {28'd0, v.eFG, v.eDG, v.fReq & ~v.eFG, v.dReq & ~v.eDG});
        expAddr = v.eDG ? v.dAddr : (v.eFG ? v.fAddr : 16'd0);
        check({tag, " port"}, {14'd0, memEn, memWe, memAddr},
              {14'd0, v.eFG | v.eDG, v.eDG & v.dWe, expAddr});
        if (v.eDG && v.dWe) begin
            check({tag, " memWdata"}, {8'd0, memWdata}, {16'd0, v.dWdata});
            refMem[v.dAddr[7:0]] = {8'd0, v.dWdata};
            sb.push_back('{isFetch: 1'b0, isStore: 1'b1, val: {8'd0, lastLoadRef}});
        end else if (v.eDG) begin
            sb.push_back('{isFetch: 1'b0, isStore: 1'b0, val: {8'd0, refMem[v.dAddr[7:0]][15:0]}});
        end else if (v.eFG) begin
            sb.push_back('{isFetch: 1'b1, isStore: 1'b0, val: refMem[v.fAddr[7:0]]});
        end
        @(posedge clock); #1;
    endtask

    // Reset cycle with both requests high: nothing may be granted or valid.
    task automatic resetCycle(input string tag);
        reset = 1;
        fetchReq = 1; fetchAddr = 16'h0005; dataReq = 1; dataWe = 0; dataAddr = 16'h0010;
        @(negedge clock);
        check({tag, " grants in reset"}, {29'd0, fetchGnt, dataGnt, memEn}, 32'd0);
        check({tag, " valids in reset"}, {30'd0, fetchValid, dataValid}, 32'd0);
        @(posedge clock); #1;
        reset = 0;
        idleInputs();
        sb.delete();
        lastFetchRef = '0;
        lastLoadRef  = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 24'hA00000 + 24'(i);
            refMem[i] = 24'hA00000 + 24'(i);
        end
        mem[16'h10]    = 24'h001234;
        refMem[16'h10] = 24'h001234;
        memRdata = '0;
        idleInputs();
        reset = 1;
        @(posedge clock); #1;
        resetCycle("init");

        // Fetch only
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0001, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0002, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // Load vs fetch, then fetch served
        tbl.push_back(mk(1, 16'h0003, 1, 0, 16'h0010, 0, 0, 1));
        tbl.push_back(mk(1, 16'h0003, 0, 0, 0, 0, 1, 0));
        // Store, load back
        tbl.push_back(mk(0, 0, 1, 1, 16'h0020, 16'hBEEF, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0020, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // Starvation: D D D F D D D F
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 16'h0004, 1, 0, 16'h0010, 0, (i % 4) == 3, (i % 4) != 3));
        // Fetch dropping its request clears the run
        tbl.push_back(mk(1, 16'h0006, 1, 0, 16'h0020, 0, 0, 1));
        tbl.push_back(mk(1, 16'h0006, 1, 0, 16'h0020, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0020, 0, 0, 1));
        tbl.push_back(mk(1, 16'h0006, 1, 0, 16'h0010, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) runCycle(tbl[i], $sformatf("v%0d", i));

        // Reset with a nonzero starvation count and a load in flight
        runCycle(mk(1, 16'h0008, 1, 0, 16'h0010, 0, 0, 1), "pre1");
        runCycle(mk(1, 16'h0008, 1, 0, 16'h0011, 0, 0, 1), "pre2");
        resetCycle("midrst1");
        check("cnt after reset", {30'd0, dut.starveCnt}, 32'd0);

        // Fetch granted, reset asserted in its response cycle
        runCycle(mk(1, 16'h0007, 0, 0, 0, 0, 1, 0), "fgnt");
        resetCycle("midrst2");
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0), "postrst");
        check("fetchInstr after reset", {8'd0, fetchInstr}, 32'd0);
        runCycle(mk(1, 16'h0009, 0, 0, 0, 0, 1, 0), "postF");
        runCycle(mk(1, 16'h000A, 1, 0, 16'h0010, 0, 0, 1), "postD1");
        runCycle(mk(1, 16'h000A, 1, 0, 16'h0010, 0, 0, 1), "postD2");
        runCycle(mk(1, 16'h000A, 1, 0, 16'h0010, 0, 0, 1), "postD3");
        runCycle(mk(1, 16'h000A, 1, 0, 16'h0010, 0, 1, 0), "postF4");
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0), "drain");

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Each cycle it grants at most one requester, drives the memory port, routes the one-cycle-late read data back to its owner, and raises per-requester stalls for the hazards unit. Data accesses have priority; a starvation counter guarantees fetch forward progress.

## Interface
- WIDTH, 16, data word and address width
- INSTRUCTIONWIDTH, 24, memory word width (instruction width)
- STARVELIMIT, 3, max consecutive data grants while fetch waits (≥1)
- CNTWIDTH, 2, starvation counter width; must hold STARVELIMIT

Reset is synchronous and active-high. All state is on the single clock `clock`.

- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- fetchReq  in  1  fetch read request
- fetchAddr  in  WIDTH  instruction address (PCF)
- fetchGnt  out  1  fetch granted this cycle
- fetchValid  out  1  fetchInstr carries the response for the previous fetch grant
- fetchInstr  out  INSTRUCTIONWIDTH  instruction; holds the last fetched value when not valid
- dataReq  in  1  data access request
- dataWe  in  1  1 = store, 0 = load
- dataAddr  in  WIDTH  data address (aluOutputM)
- dataWdata  in  WIDTH  store data
- dataGnt  out  1  data granted this cycle
- dataValid  out  1  load data valid, or store complete
- dataRdata  out  WIDTH  memRdata[WIDTH-1:0]; holds the last load value when not valid
- memEn  out  1  memory port active
- memWe  out  1  memory write enable
- memAddr  out  WIDTH  memory address
- memWdata  out  INSTRUCTIONWIDTH  store data, zero-extended
- memRdata  in  INSTRUCTIONWIDTH  synchronous read data, valid the cycle after the address is sampled
- stallFetch  out  1  fetchReq & !fetchGnt
- stallData  out  1  dataReq & !dataGnt

## Operation
- Grant logic is combinational from the requests, the starvation counter and reset:
  - dataGnt = dataReq & !(fetchReq & cnt==STARVELIMIT)
  - fetchGnt = fetchReq & !dataGnt
  - During reset, both grants are 0 and memEn is 0.
- Port mux:
  - On dataGnt, memAddr = dataAddr, memWe = dataWe, and memWdata = dataWdata zero-extended.
  - On fetchGnt, memAddr = fetchAddr and memWe = 0.
  - memEn = fetchGnt | dataGnt.
  - With no grant, memAddr = 0 and memWe = 0.
- Response FSM states: IDLE, RESP_F, RESP_LD, RESP_ST. Next state is set from this cycle's grant:
  - fetchGnt → RESP_F
  - dataGnt & !dataWe → RESP_LD
  - dataGnt & dataWe → RESP_ST
  - no grant → IDLE
  - Back-to-back grants are allowed, so the FSM can move from any state to any state every cycle.
- Outputs by state:
  - RESP_F: fetchValid = 1 and fetchInstr = memRdata. The hold register captures memRdata at the end of the cycle.
  - RESP_LD: dataValid = 1 and dataRdata = memRdata[WIDTH-1:0]. The load-hold register captures.
  - RESP_ST: dataValid = 1 and dataRdata = load-hold (no read data).
  - Otherwise: both valids are 0 and the outputs show the hold registers.
- Starvation counter cnt:
  - Increments on dataGnt while fetchReq = 1.
  - Clears on fetchGnt, or when fetchReq = 0.
  - Saturates at STARVELIMIT.
- Reset values: state IDLE, cnt 0, both hold registers 0. Hence fetchValid = 0, dataValid = 0, fetchInstr = 0, dataRdata = 0.

## Timing
- Grant and stall: 0-cycle, combinational in the request cycle.
- Response latency: exactly 1 cycle after the grant, for both requesters.
- Throughput: 1 access per cycle.
- Worst-case fetch wait: STARVELIMIT cycles of continuous data traffic.
- Simultaneous requests:
  - Data wins while cnt < STARVELIMIT.
  - Fetch wins at cnt == STARVELIMIT; the losing data request stalls exactly 1 cycle.
- Requesters must hold their request and address stable while stalled.
- The arbiter keeps no request queue; a dropped request is simply not served.
- Reset asserted mid-operation: any outstanding response is discarded, and valids are 0 in the cycle after reset.
- Address wrap-around needs no special handling; the address is passed through unmodified.

## Structure
- The package `mem_arb_pkg` contains:
  - the `arb_state_t` enum (IDLE, RESP_F, RESP_LD, RESP_ST)
  - the default STARVELIMIT constant
- One sub-module, `starve_counter` (saturating counter with inc/clr, parameterised by CNTWIDTH and limit), is natural.
- Everything else is flat in mem_port_arbiter: grant logic, port mux, FSM, hold registers.

## Test plan
- Fetch only: fetchReq = 1 with fetchAddr 0,1,2 on consecutive cycles, memory preloaded with 0xA00000+addr.
  - Required: fetchGnt = 1 every cycle.
  - Required: fetchValid = 1 from cycle 2 with fetchInstr 0xA00000, 0xA00001, 0xA00002.
  - Required: stallFetch = 0 throughout.
- Load vs fetch, one cycle: both requests, dataWe = 0, dataAddr = 0x0010 (holding 0x001234).
  - Required: dataGnt = 1 and stallFetch = 1.
  - Required: the next cycle has dataValid = 1 and dataRdata = 0x1234; fetch is granted that cycle.
- Store: dataWe = 1, dataAddr = 0x0020, dataWdata = 0xBEEF.
  - Required: memWe = 1 and memWdata = 0x00BEEF.
  - Required: dataValid = 1 the next cycle.
  - Required: a later load of 0x0020 returns 0xBEEF.
- Starvation: dataReq and fetchReq held high for 8 cycles, STARVELIMIT = 3.
  - Required grant pattern: D, D, D, F, D, D, D, F.
  - Required: stallData = 1 in exactly cycles 4 and 8.
- Reset mid-operation: grant a fetch, assert reset in the response cycle.
  - Required: valids are 0, fetchInstr = 0 and cnt = 0 after reset.
  - Required: the first post-reset fetch returns correct data.
